// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
package seg7_pkg;

  // Scan sequencer states; BLANK is reachable only with ghost blanking compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  // Segments per digit, including the decimal point.
  localparam int unsigned SEG_WIDTH_DEFAULT = 8;

  // Maps one logical bit (1 = lit / enabled) onto the board's electrical level.
  function automatic logic apply_polarity(input logic value, input bit led_logic);
    return led_logic ? value : ~value;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Pattern-in / display-out bundle between walking_circle, the scan driver and the board.
interface seg7_scan_mux_if #(
  parameter int unsigned NUM_OF_DISPLAYS = 6,
  parameter int unsigned SEG_WIDTH       = 8
);

  logic                                        tick_i;
  logic [NUM_OF_DISPLAYS-1:0][SEG_WIDTH-1:0]   seg7_i;
  logic [SEG_WIDTH-1:0]                        seg_o;
  logic [NUM_OF_DISPLAYS-1:0]                  digit_sel_o;
  logic                                        frame_done_o;

  // Pattern source / tick source side.
  modport master (
    output tick_i,
    output seg7_i,
    input  seg_o,
    input  digit_sel_o,
    input  frame_done_o
  );

  // Scan driver side.
  modport slave (
    input  tick_i,
    input  seg7_i,
    output seg_o,
    output digit_sel_o,
    output frame_done_o
  );

endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment scan driver.
// Shadows a whole frame of digit patterns at frame start and walks one shared segment bus
// across one-hot digit enables on each tick. Optional ghost blanking (one dark tick after
// every digit) is enabled by defining SEG7_SCAN_GHOST_BLANK_EN.
module seg7_scan_mux #(
  parameter int unsigned NUM_OF_DISPLAYS = 6,
  parameter int unsigned SEG_WIDTH       = seg7_pkg::SEG_WIDTH_DEFAULT,
  parameter int unsigned DWELL_TICKS     = 4,
  parameter bit          LED_LOGIC       = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  seg7_scan_mux_if.slave   scan_if
);

  import seg7_pkg::*;

  localparam int unsigned IDX_W   = $clog2(NUM_OF_DISPLAYS);
  localparam int unsigned DWELL_W = $clog2(DWELL_TICKS + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_OF_DISPLAYS - 1);
  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL_TICKS - 1);

  localparam logic [SEG_WIDTH-1:0]       SEG_INACTIVE = {SEG_WIDTH{~LED_LOGIC}};
  localparam logic [NUM_OF_DISPLAYS-1:0] SEL_INACTIVE = {NUM_OF_DISPLAYS{~LED_LOGIC}};

  typedef logic [NUM_OF_DISPLAYS-1:0][SEG_WIDTH-1:0] frame_t;

  scan_state_e                r_state;
  logic [IDX_W-1:0]           r_idx;
  logic [DWELL_W-1:0]         r_dwell;
  frame_t                     r_shadow;
  logic [SEG_WIDTH-1:0]       r_seg;
  logic [NUM_OF_DISPLAYS-1:0] r_sel;
  logic                       r_frame_done;

  scan_state_e                w_state_d;
  logic [IDX_W-1:0]           w_idx_d;
  logic [DWELL_W-1:0]         w_dwell_d;
  frame_t                     w_shadow_d;
  logic                       w_frame_done_d;
  logic                       w_advance;

  logic [SEG_WIDTH-1:0]       w_seg_logical;
  logic [NUM_OF_DISPLAYS-1:0] w_sel_logical;
  logic [SEG_WIDTH-1:0]       w_seg_d;
  logic [NUM_OF_DISPLAYS-1:0] w_sel_d;

  // Next-state: sequencer, dwell counter, digit index and frame shadow.
  always_comb begin
    w_state_d      = r_state;
    w_idx_d        = r_idx;
    w_dwell_d      = r_dwell;
    w_shadow_d     = r_shadow;
    w_frame_done_d = 1'b0;
    w_advance      = 1'b0;

    case (r_state)
      IDLE: begin
        if (scan_if.tick_i) begin
          w_shadow_d = scan_if.seg7_i;
          w_idx_d    = '0;
          w_dwell_d  = '0;
          w_state_d  = SHOW;
        end
      end
      SHOW: begin
        if (scan_if.tick_i) begin
          if (r_dwell == LAST_DWELL) begin
            w_dwell_d = '0;
`ifdef SEG7_SCAN_GHOST_BLANK_EN
            w_state_d = BLANK;
`else
            w_advance = 1'b1;
`endif
          end else begin
            w_dwell_d = r_dwell + 1'b1;
          end
        end
      end
      BLANK: begin
`ifdef SEG7_SCAN_GHOST_BLANK_EN
        if (scan_if.tick_i) begin
          w_advance = 1'b1;
        end
`else
        w_state_d = IDLE;
`endif
      end
      default: w_state_d = IDLE;
    endcase

    // Step to the next digit; the shadow is only refreshed when the frame wraps.
    if (w_advance) begin
      w_state_d = SHOW;
      if (r_idx == LAST_IDX) begin
        w_idx_d        = '0;
        w_shadow_d     = scan_if.seg7_i;
        w_frame_done_d = 1'b1;
      end else begin
        w_idx_d = r_idx + 1'b1;
      end
    end
  end

  // Output decode from the next state, so outputs are registered alongside the state.
  always_comb begin
    w_seg_logical = '0;
    w_sel_logical = '0;
    if (w_state_d == SHOW) begin
      for (int k = 0; k < int'(NUM_OF_DISPLAYS); k++) begin
        if (w_idx_d == IDX_W'(k)) begin
          w_sel_logical[k] = 1'b1;
          w_seg_logical    = w_shadow_d[k];
        end
      end
    end
    for (int b = 0; b < int'(SEG_WIDTH); b++) begin
      w_seg_d[b] = apply_polarity(w_seg_logical[b], LED_LOGIC);
    end
    for (int d = 0; d < int'(NUM_OF_DISPLAYS); d++) begin
      w_sel_d[d] = apply_polarity(w_sel_logical[d], LED_LOGIC);
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_dwell      <= '0;
      r_shadow     <= '0;
      r_seg        <= SEG_INACTIVE;
      r_sel        <= SEL_INACTIVE;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_dwell      <= w_dwell_d;
      r_shadow     <= w_shadow_d;
      r_seg        <= w_seg_d;
      r_sel        <= w_sel_d;
      r_frame_done <= w_frame_done_d;
    end
  end

  assign scan_if.seg_o        = r_seg;
  assign scan_if.digit_sel_o  = r_sel;
  assign scan_if.frame_done_o = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux.
// dut_a: DWELL_TICKS=1, active-high; dut_b: DWELL_TICKS=1, active-low;
// dut_c: DWELL_TICKS=2, active-high (ghost blank expectations follow SEG7_SCAN_GHOST_BLANK_EN).
module tb_seg7_scan_mux;

  logic            clk;
  logic            rst;
  logic            tick;
  logic [5:0][7:0] seg7;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_mux_if #(.NUM_OF_DISPLAYS(6), .SEG_WIDTH(8)) if_a ();
  seg7_scan_mux_if #(.NUM_OF_DISPLAYS(6), .SEG_WIDTH(8)) if_b ();
  seg7_scan_mux_if #(.NUM_OF_DISPLAYS(6), .SEG_WIDTH(8)) if_c ();

  assign if_a.tick_i = tick;
  assign if_b.tick_i = tick;
  assign if_c.tick_i = tick;
  assign if_a.seg7_i = seg7;
  assign if_b.seg7_i = seg7;
  assign if_c.seg7_i = seg7;

  seg7_scan_mux #(.NUM_OF_DISPLAYS(6), .SEG_WIDTH(8), .DWELL_TICKS(1), .LED_LOGIC(1'b1)) dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .scan_if (if_a)
  );

  seg7_scan_mux #(.NUM_OF_DISPLAYS(6), .SEG_WIDTH(8), .DWELL_TICKS(1), .LED_LOGIC(1'b0)) dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .scan_if (if_b)
  );

  seg7_scan_mux #(.NUM_OF_DISPLAYS(6), .SEG_WIDTH(8), .DWELL_TICKS(2), .LED_LOGIC(1'b1)) dut_c (
    .clk_i   (clk),
    .rst_i   (rst),
    .scan_if (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At most one digit enabled at any sampled instant.
  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(if_a.digit_sel_o) || !$onehot0(~if_b.digit_sel_o)) begin
      n_fail++;
      $display("FAIL onehot_sel: a=%b b=%b required at most one active", if_a.digit_sel_o,
               if_b.digit_sel_o);
    end
  end

  task automatic tick_pulse();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_a.seg_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_seg_a: got %h want 00", if_a.seg_o);
    end
    n_checks++;
    if (if_a.digit_sel_o !== 6'b000000) begin
      n_fail++; $display("FAIL reset_sel_a: got %b want 000000", if_a.digit_sel_o);
    end
    n_checks++;
    if (if_a.frame_done_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_fd_a: got %b want 0", if_a.frame_done_o);
    end
    n_checks++;
    if (if_b.seg_o !== 8'hFF) begin
      n_fail++; $display("FAIL reset_seg_b: got %h want FF", if_b.seg_o);
    end
    n_checks++;
    if (if_b.digit_sel_o !== 6'b111111) begin
      n_fail++; $display("FAIL reset_sel_b: got %b want 111111", if_b.digit_sel_o);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (if_a.digit_sel_o !== 6'b000000 || if_a.seg_o !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_no_tick: sel=%b seg=%h want 000000/00", if_a.digit_sel_o, if_a.seg_o);
    end
  endtask

  task automatic test_basic_scan();
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    logic       exp_fd;
    do_reset();
    for (int k = 0; k < 6; k++) seg7[k] = 8'h10 + 8'(k);
    for (int i = 0; i < 7; i++) begin
      tick_pulse();
      exp_sel = 6'b000001 << (i % 6);
      exp_seg = 8'h10 + 8'(i % 6);
      exp_fd  = (i == 6);
      n_checks++;
      if (if_a.digit_sel_o !== exp_sel || if_a.seg_o !== exp_seg
          || if_a.frame_done_o !== exp_fd) begin
        n_fail++;
        $display("FAIL basic_scan[%0d]: sel=%b seg=%h fd=%b want %b/%h/%b", i,
                 if_a.digit_sel_o, if_a.seg_o, if_a.frame_done_o, exp_sel, exp_seg, exp_fd);
      end
    end
    @(negedge clk);
    n_checks++;
    if (if_a.frame_done_o !== 1'b0) begin
      n_fail++; $display("FAIL frame_done_width: got %b want 0", if_a.frame_done_o);
    end
  endtask

  task automatic test_tear_free();
    do_reset();
    for (int k = 0; k < 6; k++) seg7[k] = 8'h01 + 8'(k);
    seg7[3] = 8'h3F;
    tick_pulse();
    tick_pulse();
    seg7[3] = 8'h06;
    tick_pulse();
    tick_pulse();
    n_checks++;
    if (if_a.digit_sel_o !== 6'b001000 || if_a.seg_o !== 8'h3F) begin
      n_fail++;
      $display("FAIL tear_same_frame: sel=%b seg=%h want 001000/3F", if_a.digit_sel_o,
               if_a.seg_o);
    end
    repeat (3) tick_pulse();
    n_checks++;
    if (if_a.frame_done_o !== 1'b1 || if_a.seg_o !== 8'h01) begin
      n_fail++;
      $display("FAIL tear_wrap: fd=%b seg=%h want 1/01", if_a.frame_done_o, if_a.seg_o);
    end
    repeat (3) tick_pulse();
    n_checks++;
    if (if_a.digit_sel_o !== 6'b001000 || if_a.seg_o !== 8'h06) begin
      n_fail++;
      $display("FAIL tear_next_frame: sel=%b seg=%h want 001000/06", if_a.digit_sel_o,
               if_a.seg_o);
    end
  endtask

  task automatic test_polarity();
    do_reset();
    n_checks++;
    if (if_b.seg_o !== 8'hFF || if_b.digit_sel_o !== 6'b111111) begin
      n_fail++;
      $display("FAIL pol_idle: seg=%h sel=%b want FF/111111", if_b.seg_o, if_b.digit_sel_o);
    end
    seg7    = '0;
    seg7[0] = 8'h3F;
    tick_pulse();
    n_checks++;
    if (if_b.seg_o !== 8'hC0 || if_b.digit_sel_o !== 6'b111110) begin
      n_fail++;
      $display("FAIL pol_drive: seg=%h sel=%b want C0/111110", if_b.seg_o, if_b.digit_sel_o);
    end
  endtask

  task automatic test_ghost_blank();
    int         k;
    bit         lit;
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    logic       exp_fd;
    do_reset();
    for (int j = 0; j < 6; j++) seg7[j] = 8'h20 + 8'(j);
    for (int t = 1; t <= 19; t++) begin
      tick_pulse();
`ifdef SEG7_SCAN_GHOST_BLANK_EN
      k      = ((t - 1) / 3) % 6;
      lit    = ((t - 1) % 3) != 2;
      exp_fd = (t == 19);
`else
      k      = ((t - 1) / 2) % 6;
      lit    = 1'b1;
      exp_fd = (t == 13);
`endif
      exp_sel = lit ? (6'b000001 << k) : 6'b000000;
      exp_seg = lit ? (8'h20 + 8'(k)) : 8'h00;
      n_checks++;
      if (if_c.digit_sel_o !== exp_sel || if_c.seg_o !== exp_seg
          || if_c.frame_done_o !== exp_fd) begin
        n_fail++;
        $display("FAIL dwell2_tick[%0d]: sel=%b seg=%h fd=%b want %b/%h/%b", t,
                 if_c.digit_sel_o, if_c.seg_o, if_c.frame_done_o, exp_sel, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    do_reset();
    for (int k = 0; k < 6; k++) seg7[k] = 8'h30 + 8'(k);
    repeat (5) tick_pulse();
    n_checks++;
    if (if_a.digit_sel_o !== 6'b010000 || if_a.seg_o !== 8'h34) begin
      n_fail++;
      $display("FAIL pre_reset_digit4: sel=%b seg=%h want 010000/34", if_a.digit_sel_o,
               if_a.seg_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (if_a.digit_sel_o !== 6'b000000 || if_a.seg_o !== 8'h00
        || if_a.frame_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_a: sel=%b seg=%h fd=%b want 000000/00/0", if_a.digit_sel_o,
               if_a.seg_o, if_a.frame_done_o);
    end
    n_checks++;
    if (if_b.digit_sel_o !== 6'b111111 || if_b.seg_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL async_reset_b: sel=%b seg=%h want 111111/FF", if_b.digit_sel_o,
               if_b.seg_o);
    end
    for (int k = 0; k < 6; k++) seg7[k] = 8'hA0 + 8'(k);
    @(negedge clk);
    rst = 1'b0;
    tick_pulse();
    n_checks++;
    if (if_a.digit_sel_o !== 6'b000001 || if_a.seg_o !== 8'hA0
        || if_a.frame_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_first: sel=%b seg=%h fd=%b want 000001/A0/0", if_a.digit_sel_o,
               if_a.seg_o, if_a.frame_done_o);
    end
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    seg7 = '0;
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_polarity();
    test_ghost_blank();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
